key_search_ctrl: RTL and testbench
==================================

# key_search_ctrl

Sequencer that brute-forces the RC4 key space by repeatedly driving the `arcfour` core. It sits between the top level and `arcfour`: it presents a candidate 24-bit key, pulses `start_sig`, waits for `arcfour_finished`, then scans the decrypted-message RAM for printable plaintext. It advances to the next key on a bad byte, and stops on the first fully valid message or when the key range is exhausted.

## Interface
- `KEY_FIRST`, default 24'h000000: first candidate key.
- `KEY_LAST`, default 24'h3FFFFF: last candidate key (inclusive).
- `MSG_LEN`, default 32: decrypted-message length in bytes (1..256).
- `clk` in 1: system clock; every flop is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle pulse (already edge-trapped) that begins a search.
- `key` out [2:0][7:0]: candidate key to `arcfour`; `key[0]` = cur_key[23:16], `key[2]` = cur_key[7:0].
- `arc_start` out 1: one-cycle start pulse to `arcfour`.
- `arc_finished` in 1: `arcfour` done level; drops within 1 cycle of `arc_start`.
- `msg_addr` out [7:0]: read address into the decrypted-message RAM.
- `msg_q` in [7:0]: RAM read data, valid 1 cycle after `msg_addr`.
- `busy` out 1: search in progress.
- `found` out 1: sticky; the key matched.
- `failed` out 1: sticky; range exhausted with no match.
- `cur_key` out 24: current or matching key.

## Operation
- States: IDLE, LAUNCH, ARM, WAIT, READ, CHECK, FOUND, FAIL.
- IDLE: on `start`, set cur_key=KEY_FIRST, clear found/failed, go to LAUNCH.
  - `start` is also accepted in FOUND and FAIL, restarting the search.
  - `start` is ignored in every other state.
- LAUNCH: `arc_start`=1 for exactly one cycle, then go to ARM.
- ARM: one dead cycle; `arc_finished` is ignored here (it may still be stale-high). Go to WAIT.
- WAIT: hold until `arc_finished`=1, then idx=0 and go to READ.
- READ/CHECK: pipelined scan.
  - `msg_addr`=idx each cycle; byte idx-1 is checked in the same cycle.
  - A byte is valid iff 8'h61 ≤ b ≤ 8'h7A or b = 8'h20.
  - First invalid byte: abort the scan and advance the key.
  - All MSG_LEN bytes valid: go to FOUND.
- Key advance:
  - If cur_key == KEY_LAST, go to FAIL.
  - Otherwise cur_key+1 (24-bit, no wrap past KEY_LAST), then LAUNCH.
- FOUND: found=1, busy=0; cur_key and `key` hold the match.
- FAIL: failed=1, busy=0; cur_key holds KEY_LAST.
- `key` is driven combinationally from cur_key. It is stable from LAUNCH until the next advance.

## Timing
- Reset values:
  - state=IDLE, cur_key=KEY_FIRST.
  - busy, found, failed, `arc_start` all 0.
  - `msg_addr`=0.
- `busy` rises the cycle after `start` and falls on entry to FOUND or FAIL.
- Per-key overhead excluding `arcfour` runtime: 3 cycles (LAUNCH, ARM, first READ) plus scan.
  - Scan takes k+1 cycles when the first bad byte is at index k.
  - A full match takes MSG_LEN+1 cycles.
- The `msg_q` check lags `msg_addr` by exactly 1 cycle; the address counter runs to MSG_LEN-1 only.
- `reset` mid-search (any state) forces IDLE next cycle, and `arc_start` is forced low.
  - `arcfour` is reset by the same signal, so it is not otherwise cancelled.
- `start` coincident with `reset`: reset wins.
- KEY_FIRST == KEY_LAST: exactly one candidate is tried.

## Structure
- Shared package `rc4_pkg` holds:
  - the state enum `ks_state_t`;
  - `key_t` (logic [2:0][7:0]);
  - constants CH_LO=8'h61, CH_HI=8'h7A, CH_SP=8'h20;
  - a function `is_plain(byte)`.
- One sub-module: `msg_scanner`. It owns the idx counter, the 1-cycle address/data alignment and the valid/abort/pass outputs. The FSM instantiates it, pulsing `scan_go` on WAIT→READ.

## Test plan
- Match on first key: KEY_FIRST=24'h000249 and a behavioural `arcfour` model whose RAM holds "attack at dawn..." (32 printable bytes) for that key.
  - Expect exactly one `arc_start`, then found=1, cur_key=24'h000249.
  - Expect busy to fall MSG_LEN+1 cycles after `arc_finished`.
- Early abort: key 0 yields byte 0 = 8'h41 and key 1 matches.
  - Expect key 0's scan to end after 1 `msg_q` check, then 2 `arc_start` pulses total and cur_key=1.
- Exhaustion: KEY_FIRST=5, KEY_LAST=7, no key matches.
  - Expect 3 `arc_start` pulses, failed=1, found=0, cur_key=7, busy=0.
- Boundary byte values:
  - message bytes 8'h60 or 8'h7B → reject.
  - 8'h20, 8'h61, 8'h7A → accept.
- Stale finished: hold `arc_finished` high through LAUNCH and ARM, dropping it in WAIT.
  - Expect no scan until its next rising level.
- Reset mid-WAIT, then `start`:
  - Expect all outputs at reset values one cycle after reset.
  - The search restarts at KEY_FIRST; `start` during busy is ignored.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-search sequencer:
// FSM states, the 3-byte key bundle and the printable-plaintext rule.
package rc4_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        ARM,
        WAIT,
        READ,
        CHECK,
        FOUND,
        FAIL
    } ks_state_t;

    typedef logic [2:0][7:0] key_t;

    localparam logic [7:0] CH_LO = 8'h61;
    localparam logic [7:0] CH_HI = 8'h7A;
    localparam logic [7:0] CH_SP = 8'h20;

    // Lower-case letters and space are the only acceptable plaintext bytes
    function automatic logic is_plain(input logic [7:0] b);
        return ((b >= CH_LO) && (b <= CH_HI)) || (b == CH_SP);
    endfunction

endpackage

// File: rtl/msg_scanner.sv
// Walks the decrypted-message RAM one byte per cycle, checking each byte
// one cycle after its address was issued to absorb the RAM read latency.
module msg_scanner
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_go,
    input  logic [7:0] msg_q,
    output logic [7:0] msg_addr,
    output logic       valid,
    output logic       abort,
    output logic       pass
);

    localparam logic [7:0] LAST_ADDR = 8'(MSG_LEN - 1);

    logic run;
    logic chk;
    logic chk_last;
    logic byte_ok;

    assign byte_ok = is_plain(msg_q);
    assign valid   = chk;
    assign abort   = chk && !byte_ok;
    assign pass    = chk && chk_last && byte_ok;

    // chk marks the cycle in which msg_q holds the byte addressed one cycle earlier
    always_ff @(posedge clk) begin
        if (reset) begin
            msg_addr <= 8'd0;
            run      <= 1'b0;
            chk      <= 1'b0;
            chk_last <= 1'b0;
        end else if (scan_go) begin
            msg_addr <= 8'd0;
            run      <= 1'b1;
            chk      <= 1'b0;
            chk_last <= 1'b0;
        end else if (abort || pass) begin
            run      <= 1'b0;
            chk      <= 1'b0;
            chk_last <= 1'b0;
        end else begin
            chk      <= run;
            chk_last <= run && (msg_addr == LAST_ADDR);
            if (run) begin
                if (msg_addr == LAST_ADDR) begin
                    run <= 1'b0;
                end else begin
                    msg_addr <= msg_addr + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/key_search_ctrl.sv
// Brute-force RC4 key sequencer: launches arcfour per candidate key and
// scans the decrypted message, stopping on the first printable result.
module key_search_ctrl
    import rc4_pkg::*;
#(
    parameter logic [23:0] KEY_FIRST = 24'h000000,
    parameter logic [23:0] KEY_LAST  = 24'h3FFFFF,
    parameter int          MSG_LEN   = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output key_t        key,
    output logic        arc_start,
    input  logic        arc_finished,
    output logic [7:0]  msg_addr,
    input  logic [7:0]  msg_q,
    output logic        busy,
    output logic        found,
    output logic        failed,
    output logic [23:0] cur_key
);

    ks_state_t state;
    logic      scan_go;
    logic      scan_valid;
    logic      scan_abort;
    logic      scan_pass;

    // arcfour expects the most significant key byte in element 0
    assign key     = {cur_key[7:0], cur_key[15:8], cur_key[23:16]};
    assign scan_go = (state == WAIT) && arc_finished;

    msg_scanner #(
        .MSG_LEN(MSG_LEN)
    ) u_scanner (
        .clk     (clk),
        .reset   (reset),
        .scan_go (scan_go),
        .msg_q   (msg_q),
        .msg_addr(msg_addr),
        .valid   (scan_valid),
        .abort   (scan_abort),
        .pass    (scan_pass)
    );

    // ARM exists so a finished level left over from the previous key is never taken as done
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cur_key   <= KEY_FIRST;
            busy      <= 1'b0;
            found     <= 1'b0;
            failed    <= 1'b0;
            arc_start <= 1'b0;
        end else begin
            arc_start <= 1'b0;
            case (state)
                IDLE, FOUND, FAIL: begin
                    if (start) begin
                        state     <= LAUNCH;
                        cur_key   <= KEY_FIRST;
                        busy      <= 1'b1;
                        found     <= 1'b0;
                        failed    <= 1'b0;
                        arc_start <= 1'b1;
                    end
                end
                LAUNCH: state <= ARM;
                ARM:    state <= WAIT;
                WAIT: begin
                    if (arc_finished) begin
                        state <= READ;
                    end
                end
                READ: state <= CHECK;
                CHECK: begin
                    if (scan_valid) begin
                        if (scan_abort) begin
                            if (cur_key == KEY_LAST) begin
                                state  <= FAIL;
                                busy   <= 1'b0;
                                failed <= 1'b1;
                            end else begin
                                cur_key   <= cur_key + 24'd1;
                                state     <= LAUNCH;
                                arc_start <= 1'b1;
                            end
                        end else if (scan_pass) begin
                            state <= FOUND;
                            busy  <= 1'b0;
                            found <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_search_ctrl.sv
// Randomized bench for key_search_ctrl: a behavioural arcfour/RAM model feeds
// per-key messages and the expected search outcome is derived from those messages.
module tb_key_search_ctrl;
    import rc4_pkg::*;

    localparam logic [23:0] A_FIRST = 24'h000249;
    localparam logic [23:0] A_LAST  = 24'h000250;
    localparam logic [23:0] B_KEY   = 24'h000100;
    localparam int          A_LEN   = 32;
    localparam int          B_LEN   = 4;
    localparam int          A_KEYS  = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        start [2];
    key_t        key_o [2];
    logic        arc_start [2];
    logic        fin [2];
    logic [7:0]  msg_addr [2];
    logic [7:0]  msg_q [2];
    logic        busy [2];
    logic        found [2];
    logic        failed [2];
    logic [23:0] cur_key [2];

    int          n_tests = 0;
    int          n_fail = 0;
    logic [7:0]  msg_tab [2][A_KEYS][32];
    logic [7:0]  bad_vals [8];
    logic [7:0]  acc_vals [3];
    int          fin_lo = 1;
    int          fin_hi = 5;
    logic        stale_mode = 1'b0;

    int          cnt [2];
    int          run_row [2];
    int          ready_row [2];
    logic        stale_left [2];

    int          pulses [2];
    int          gap_n [2];
    int          gap_log [2][16];

    key_search_ctrl #(
        .KEY_FIRST(A_FIRST),
        .KEY_LAST (A_LAST),
        .MSG_LEN  (A_LEN)
    ) dut_a (
        .clk         (clk),
        .reset       (reset),
        .start       (start[0]),
        .key         (key_o[0]),
        .arc_start   (arc_start[0]),
        .arc_finished(fin[0]),
        .msg_addr    (msg_addr[0]),
        .msg_q       (msg_q[0]),
        .busy        (busy[0]),
        .found       (found[0]),
        .failed      (failed[0]),
        .cur_key     (cur_key[0])
    );

    key_search_ctrl #(
        .KEY_FIRST(B_KEY),
        .KEY_LAST (B_KEY),
        .MSG_LEN  (B_LEN)
    ) dut_b (
        .clk         (clk),
        .reset       (reset),
        .start       (start[1]),
        .key         (key_o[1]),
        .arc_start   (arc_start[1]),
        .arc_finished(fin[1]),
        .msg_addr    (msg_addr[1]),
        .msg_q       (msg_q[1]),
        .busy        (busy[1]),
        .found       (found[1]),
        .failed      (failed[1]),
        .cur_key     (cur_key[1])
    );

    function automatic logic [23:0] key_val(input key_t k);
        return {k[0], k[1], k[2]};
    endfunction

    function automatic logic [23:0] first_key(input int g);
        return (g == 0) ? A_FIRST : B_KEY;
    endfunction

    // arcfour stand-in: the RAM reads as zeros until the run for the latched key finishes
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (reset) begin
                fin[g]        <= 1'b0;
                cnt[g]        <= 0;
                run_row[g]    <= 0;
                ready_row[g]  <= -1;
                stale_left[g] <= 1'b0;
                msg_q[g]      <= 8'h00;
            end else begin
                if (arc_start[g]) begin
                    run_row[g]    <= int'(key_val(key_o[g]) - first_key(g));
                    cnt[g]        <= int'($urandom_range(fin_hi, fin_lo));
                    ready_row[g]  <= -1;
                    stale_left[g] <= stale_mode;
                    if (!stale_mode) fin[g] <= 1'b0;
                end else if (stale_left[g]) begin
                    stale_left[g] <= 1'b0;
                    fin[g]        <= 1'b0;
                end else if (cnt[g] > 0) begin
                    cnt[g] <= cnt[g] - 1;
                    if (cnt[g] == 1) begin
                        fin[g]       <= 1'b1;
                        ready_row[g] <= run_row[g];
                    end
                end
                msg_q[g] <= (ready_row[g] < 0) ? 8'h00 : msg_tab[g][ready_row[g]][msg_addr[g]];
            end
        end
    end

    // Per-key latency log: cycles from finished rising to the next launch or end of search
    initial begin
        logic busy_q [2];
        logic fin_q [2];
        logic have_t0 [2];
        int   cyc [2];
        int   t0 [2];
        for (int g = 0; g < 2; g++) begin
            busy_q[g] = 1'b0; fin_q[g] = 1'b0; have_t0[g] = 1'b0;
            cyc[g] = 0; t0[g] = 0; pulses[g] = 0; gap_n[g] = 0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (reset || (start[g] && !busy[g])) begin
                    pulses[g] = 0; gap_n[g] = 0; have_t0[g] = 1'b0;
                end
                if (arc_start[g]) begin
                    pulses[g]++;
                    if (have_t0[g] && gap_n[g] < 16) begin
                        gap_log[g][gap_n[g]] = cyc[g] - t0[g];
                        gap_n[g]++;
                    end
                    have_t0[g] = 1'b0;
                end
                if (fin[g] && !fin_q[g]) begin
                    t0[g] = cyc[g];
                    have_t0[g] = 1'b1;
                end
                if (busy_q[g] && !busy[g] && have_t0[g] && gap_n[g] < 16) begin
                    gap_log[g][gap_n[g]] = cyc[g] - t0[g];
                    gap_n[g]++;
                    have_t0[g] = 1'b0;
                end
                busy_q[g] = busy[g];
                fin_q[g]  = fin[g];
                cyc[g]++;
            end
        end
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rand_plain();
        int k;
        k = int'($urandom_range(26, 0));
        return (k == 26) ? 8'h20 : 8'(8'h61 + k);
    endfunction

    task automatic fill_row(input int g, input int r, input int bad_at, input logic [7:0] bad_val);
        for (int i = 0; i < 32; i++) msg_tab[g][r][i] = rand_plain();
        if (bad_at >= 0) msg_tab[g][r][bad_at] = bad_val;
    endtask

    task automatic fill_random(input int g, input int len, input int nk);
        for (int r = 0; r < nk; r++) begin
            if ($urandom_range(3, 0) != 0)
                fill_row(g, r, int'($urandom_range(len - 1, 0)), bad_vals[$urandom_range(7, 0)]);
            else
                fill_row(g, r, -1, 8'h00);
        end
    endtask

    // First offending byte index, or -1 when the whole message is lower-case text and spaces
    function automatic int first_bad(input int g, input int r, input int len);
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            b = msg_tab[g][r][i];
            if (!(b == " " || (b >= "a" && b <= "z"))) return i;
        end
        return -1;
    endfunction

    task automatic apply_stimulus(input int g, input bit extra_start);
        bit done;
        @(posedge clk); #1 start[g] = 1'b1;
        @(posedge clk); #1 start[g] = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start[g] = extra_start && (c == 4);
            if (!busy[g]) begin
                done = 1'b1;
                break;
            end
        end
        start[g] = 1'b0;
        if (!done) check_output("search_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_search(input int g, input string tag);
        int          len;
        int          nk;
        int          tried;
        int          hit;
        int          fb;
        int          exp_gap [8];
        logic [23:0] exp_key;
        len   = (g == 0) ? A_LEN : B_LEN;
        nk    = (g == 0) ? A_KEYS : 1;
        tried = 0;
        hit   = -1;
        for (int r = 0; r < nk && hit < 0; r++) begin
            fb = first_bad(g, r, len);
            exp_gap[r] = ((fb < 0) ? len - 1 : fb) + 3;
            tried++;
            if (fb < 0) hit = r;
        end
        exp_key = (hit >= 0) ? first_key(g) + 24'(hit) : first_key(g) + 24'(nk - 1);
        check_output({tag, ".arc_start_pulses"}, pulses[g], tried);
        check_output({tag, ".keys_scanned"}, gap_n[g], tried);
        for (int r = 0; r < tried && r < gap_n[g]; r++)
            check_output($sformatf("%s.latency_key%0d", tag, r), gap_log[g][r], exp_gap[r]);
        check_output({tag, ".found"}, found[g], (hit >= 0));
        check_output({tag, ".failed"}, failed[g], (hit < 0));
        check_output({tag, ".busy"}, busy[g], 1'b0);
        check_output({tag, ".cur_key"}, cur_key[g], exp_key);
        check_output({tag, ".key_port"}, key_val(key_o[g]), exp_key);
    endtask

    task automatic check_reset_values(input int g, input string tag);
        check_output({tag, ".busy"}, busy[g], 1'b0);
        check_output({tag, ".found"}, found[g], 1'b0);
        check_output({tag, ".failed"}, failed[g], 1'b0);
        check_output({tag, ".arc_start"}, arc_start[g], 1'b0);
        check_output({tag, ".msg_addr"}, msg_addr[g], 8'h00);
        check_output({tag, ".cur_key"}, cur_key[g], first_key(g));
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation still running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        string msg_line;
        bit    seen;
        msg_line = "attack at dawn ";
        bad_vals = '{8'h60, 8'h7B, 8'h41, 8'h00, 8'hFF, 8'h1F, 8'h21, 8'h5A};
        acc_vals = '{8'h20, 8'h61, 8'h7A};
        start[0] = 1'b0;
        start[1] = 1'b0;

        // start while reset is held must be lost
        repeat (3) @(posedge clk);
        #1 start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0; reset = 1'b0;
        @(negedge clk); @(negedge clk);
        check_reset_values(0, "reset_a");
        check_reset_values(1, "reset_b");

        for (int r = 0; r < A_KEYS; r++) fill_row(0, r, int'($urandom_range(31, 0)), 8'h41);
        for (int i = 0; i < 32; i++) msg_tab[0][0][i] = msg_line[i % msg_line.len()];
        apply_stimulus(0, 1'b0);
        check_search(0, "first_key");

        fill_row(0, 0, 0, 8'h41);
        for (int i = 0; i < 32; i++) msg_tab[0][1][i] = msg_line[i % msg_line.len()];
        apply_stimulus(0, 1'b0);
        check_search(0, "early_abort");

        for (int r = 0; r < A_KEYS; r++)
            fill_row(0, r, int'($urandom_range(31, 0)), (r % 2 == 0) ? 8'h60 : 8'h7B);
        apply_stimulus(0, 1'b0);
        check_search(0, "exhaust");

        fill_row(0, 0, 0, 8'h60);
        fill_row(0, 1, 31, 8'h7B);
        for (int r = 2; r < 6; r++)
            fill_row(0, r, int'($urandom_range(31, 0)), (r % 2 == 0) ? 8'h7B : 8'h60);
        for (int i = 0; i < 32; i++) msg_tab[0][6][i] = acc_vals[i % 3];
        apply_stimulus(0, 1'b0);
        check_search(0, "boundary");

        stale_mode = 1'b1;
        fill_random(0, A_LEN, A_KEYS);
        apply_stimulus(0, 1'b0);
        check_search(0, "stale_finished");
        stale_mode = 1'b0;

        fill_row(1, 0, -1, 8'h00);
        apply_stimulus(1, 1'b0);
        check_search(1, "single_match");
        fill_row(1, 0, 3, 8'h7B);
        apply_stimulus(1, 1'b0);
        check_search(1, "single_reject");

        for (int n = 0; n < 6; n++) begin
            stale_mode = ($urandom_range(1, 0) == 1);
            fill_random(0, A_LEN, A_KEYS);
            apply_stimulus(0, 1'b0);
            check_search(0, $sformatf("random%0d", n));
        end
        stale_mode = 1'b0;

        // reset while waiting on arcfour, then a clean restart that ignores a second start
        fin_lo = 5; fin_hi = 5;
        fill_random(0, A_LEN, A_KEYS);
        @(posedge clk); #1 start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = arc_start[0];
        end
        check_output("mid_wait.launch_seen", seen, 1'b1);
        @(negedge clk); @(negedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_reset_values(0, "mid_wait_reset");
        fin_lo = 1; fin_hi = 5;
        apply_stimulus(0, 1'b1);
        check_search(0, "after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
